// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_stream
// Brief   : Async-FIFO read-side drain into a 2-entry registered skid buffer
//           with a valid/ready output stream and a delivered-word counter.
// Rev     : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    output logic [CNTW-1:0]  rd_count
);

    localparam logic [1:0] c_OCC_FULL = 2'd2;

    logic [1:0]       r_occ;
    logic             r_head;
    logic             r_tail;
    logic [DSIZE-1:0] r_mem [0:1];
    logic [CNTW-1:0]  r_count;

    logic             w_push;
    logic             w_accept;

    // Pop decision looks only at registered occupancy, never at m_ready.
    assign rinc     = rrst_n & ~rempty & ~flush & (r_occ != c_OCC_FULL);
    assign w_push   = rinc;
    assign w_accept = m_valid & m_ready;

    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_mem[r_head];
    assign rd_count = r_count;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_occ    <= 2'd0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + 1'b1;
            end
            // Flush drops buffered words; entry contents are left stale.
            if (flush) begin
                r_occ  <= 2'd0;
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_tail] <= rdata;
                    r_tail        <= ~r_tail;
                end
                if (w_accept) begin
                    r_head <= ~r_head;
                end
                case ({w_push, w_accept})
                    2'b10:   r_occ <= r_occ + 2'd1;
                    2'b01:   r_occ <= r_occ - 2'd1;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_stream
// Brief   : Directed and randomised self-checking bench for fifo_rd_stream.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int CNTW  = 16;

    logic             rclk;
    logic             rrst_n;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;
    logic             flush;
    logic [CNTW-1:0]  rd_count;

    fifo_rd_stream #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .flush    (flush),
        .rd_count (rd_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [DSIZE-1:0] src[$];
    logic [DSIZE-1:0] mbuf[$];
    logic [CNTW-1:0]  mcount;
    logic             force_empty;
    logic             s_rinc, s_valid;
    logic [DSIZE-1:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rempty = (src.size() == 0) || force_empty;
        rdata  = (src.size() != 0) ? src[0] : '0;
    endtask

    // One clock: checks against the queue model before the edge, updates after.
    task automatic cycle();
        logic exp_rinc, acc;
        drive();
        #4;
        exp_rinc = rrst_n & ~rempty & ~flush & (mbuf.size() < 2);
        acc      = (mbuf.size() != 0) && m_ready;
        chk("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
        chk("no_underflow", {31'd0, rinc & rempty}, 32'd0);
        chk("no_pop_when_full", {31'd0, rinc & (mbuf.size() == 2)}, 32'd0);
        chk("m_valid", {31'd0, m_valid}, {31'd0, mbuf.size() != 0});
        if (mbuf.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, mbuf[0]});
        chk("rd_count", {16'd0, rd_count}, {16'd0, mcount});
        s_rinc  = rinc;
        s_valid = m_valid;
        s_data  = m_data;
        @(posedge rclk);
        #1;
        if (acc) begin
            void'(mbuf.pop_front());
            mcount = mcount + 1'b1;
        end
        if (flush) mbuf.delete();
        else if (exp_rinc) mbuf.push_back(src.pop_front());
    endtask

    task automatic do_reset();
        rrst_n      = 1'b0;
        flush       = 1'b0;
        force_empty = 1'b0;
        m_ready     = 1'b1;
        src.delete();
        mbuf.delete();
        mcount      = '0;
        drive();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [DSIZE-1:0] w5 [0:4];
        logic [DSIZE-1:0] held;
        int               budget;

        // 1: reset held, source empty
        do_reset();
        rrst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t1_rinc", {31'd0, s_rinc}, 32'd0);
            chk("t1_valid", {31'd0, s_valid}, 32'd0);
            chk("t1_data", {24'd0, s_data}, 32'd0);
        end
        rrst_n = 1'b1;

        // 2: three words streamed with m_ready=1
        do_reset();
        src = '{8'h11, 8'h22, 8'h33};
        begin
            logic [4:0] e_rinc  = 5'b00111;
            logic [4:0] e_valid = 5'b01110;
            logic [7:0] e_data [0:4] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
            for (int i = 0; i < 5; i++) begin
                cycle();
                chk("t2_rinc", {31'd0, s_rinc}, {31'd0, e_rinc[i]});
                chk("t2_valid", {31'd0, s_valid}, {31'd0, e_valid[i]});
                if (e_valid[i]) chk("t2_data", {24'd0, s_data}, {24'd0, e_data[i]});
            end
        end
        chk("t2_count", {16'd0, rd_count}, 32'd3);

        // 3: stall with five words queued
        do_reset();
        w5 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int i = 0; i < 5; i++) src.push_back(w5[i]);
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_rinc", {31'd0, s_rinc}, {31'd0, i < 2});
            if (i >= 1) chk("t3_hold", {24'd0, s_data}, 32'hA1);
        end
        chk("t3_src_left", src.size(), 32'd3);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("t3_count", {16'd0, rd_count}, 32'd5);
        chk("t3_drained", {31'd0, m_valid}, 32'd0);

        // 4: random ready and random empty over 1000 words
        do_reset();
        for (int i = 0; i < 1000; i++) src.push_back(DSIZE'($urandom));
        budget = 0;
        while (mcount != 16'd1000 && budget < 10000) begin
            m_ready     = $urandom_range(0, 1) == 1;
            force_empty = $urandom_range(0, 3) == 0;
            cycle();
            budget++;
        end
        force_empty = 1'b0;
        chk("t4_all_delivered", {16'd0, mcount}, 32'd1000);
        chk("t4_count", {16'd0, rd_count}, 32'd1000);

        // 5: flush with buffer full
        do_reset();
        src = '{8'h51, 8'h52, 8'h53, 8'h54};
        m_ready = 1'b0;
        repeat (3) cycle();
        chk("t5_full_valid", {31'd0, m_valid}, 32'd1);
        flush = 1'b1;
        cycle();
        chk("t5_flush_rinc", {31'd0, s_rinc}, 32'd0);
        flush = 1'b0;
        #1;
        chk("t5_after_flush_valid", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b1;
        budget = 0;
        do begin
            cycle();
            budget++;
        end while (!s_valid && budget < 10);
        chk("t5_first_after_flush", {24'd0, s_data}, 32'h53);
        repeat (4) cycle();
        chk("t5_count", {16'd0, rd_count}, 32'd2);

        // 6: counter wrap, then asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 65534; i++) src.push_back(DSIZE'(i));
        budget = 0;
        while (mcount != 16'hFFFE && budget < 70000) begin
            cycle();
            budget++;
        end
        chk("t6_preset", {16'd0, rd_count}, 32'hFFFE);
        src = '{8'h61, 8'h62, 8'h63};
        budget = 0;
        while (mcount != 16'h0001 && budget < 20) begin
            cycle();
            budget++;
        end
        repeat (2) cycle();
        chk("t6_wrap", {16'd0, rd_count}, 32'h0001);

        src = '{8'h5A, 8'h6B, 8'h7C};
        m_ready = 1'b0;
        repeat (3) cycle();
        chk("t6_pre_rst_valid", {31'd0, m_valid}, 32'd1);
        chk("t6_pre_rst_data", {24'd0, m_data}, 32'h5A);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("t6_rst_rinc", {31'd0, rinc}, 32'd0);
        chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, m_data}, 32'd0);
        chk("t6_rst_count", {16'd0, rd_count}, 32'd0);
        do_reset();
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer for the asynchronous FIFO, in the rclk domain. It drains words from the FIFO memory using the FIFO's empty flag and read-increment. It presents the words on a valid/ready output stream through a 2-entry registered skid buffer, and it counts delivered words. It sits between the read-pointer/empty logic plus the memory read port, and the downstream read-domain logic.

Parameters:
DSIZE, 8, data word width (matches the FIFO memory width)
CNTW, 16, width of the delivered-word counter

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  reset, asynchronous, active-low
rempty  input  1  registered FIFO empty flag from the read-pointer logic
rdata  input  DSIZE  FIFO memory read data at the current read address; combinational read, valid whenever rempty=0
rinc  output  1  pop request to the read-pointer logic
m_valid  output  1  output word valid
m_data  output  DSIZE  output word
m_ready  input  1  downstream accept
flush  input  1  synchronous clear of the output buffer
rd_count  output  CNTW  number of words accepted downstream, wraps modulo 2^CNTW

Behaviour:
- Reset (rrst_n=0, asynchronous):
  - occupancy occ=0, head/tail indices=0, both buffer entries=0.
  - m_valid=0, m_data=0, rd_count=0.
  - rinc=0 because it is gated by rrst_n.
- Buffer: 2-entry circular FIFO of DSIZE words.
  - occ ranges 0..2.
  - m_valid = (occ!=0).
  - m_data = entry[head].
  - Both are driven from registers only.
- Pop rule: rinc = rrst_n & ~rempty & ~flush & (occ<2).
  - rinc has no combinational path from m_ready. This is a timing requirement.
- Push: when rinc=1, rdata is written into entry[tail] at the rclk edge and tail toggles.
- Accept: when m_valid & m_ready, head toggles at the edge and rd_count increments by 1.
  - rd_count wraps from all-ones to 0.
- Occupancy update per edge:
  - occ += push.
  - occ -= accept.
  - Push and accept in the same cycle leave occ unchanged.
- Latency: a word at the FIFO head with rempty=0 in cycle N is popped in N and appears on m_valid/m_data in N+1.
  - With m_ready held at 1 and the FIFO continuously non-empty, throughput is 1 word/cycle steady state and occ stays at 1.
- Stall: with m_ready=0, at most 2 words are popped, then rinc=0 until an accept.
  - m_data/m_valid must stay stable while m_valid=1 and m_ready=0.
- Empty: rempty=1 means no pop. The buffer keeps delivering what it already holds.
- Ordering: words leave in exactly the order they were popped. No duplication, no loss.
- Flush (synchronous, has priority):
  - At the edge with flush=1: occ=0, head=tail=0, and m_valid=0 in the next cycle.
  - rinc=0 during flush, so the FIFO is not drained.
  - An accept in the flush cycle still counts in rd_count.
  - Entry contents may keep stale data.
- Mid-operation reset: everything returns to reset values immediately. Buffered words are discarded.
- No underflow is possible: the block never asserts rinc while rempty=1. The bench must check this every cycle.

Test Plan:
1. Reset, rempty=1, m_ready=1 -> rinc=0, m_valid=0, m_data=0, rd_count=0 for 10 cycles.
2. FIFO holds 0x11,0x22,0x33, m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first pop; rd_count=3.
3. FIFO holds 5 words, m_ready=0 -> exactly 2 pops, occ=2, m_data=first word held stable. Then m_ready=1 -> remaining words delivered in order; rd_count=5; rinc never asserted while occ=2.
4. Random m_ready (50%) and random rempty over 1000 words -> scoreboard shows an in-order, exact match; rinc never asserted while rempty=1 or occ=2.
5. occ=2 with m_ready=0, assert flush for 1 cycle -> next cycle m_valid=0; rinc=0 during flush; after flush, new words are delivered correctly with no stale word.
6. Preset rd_count to 0xFFFE via 65534 accepts (CNTW=16), then deliver 3 words -> rd_count wraps to 0x0001. Separately, assert rrst_n=0 mid-stream -> all outputs are 0 asynchronously.
